// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types, defaults and helpers for the conv tile load scheduler
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IN_FM  = 2'd0,
        ST_WEIGHT = 2'd1,
        ST_OUT_FM = 2'd2
    } stream_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int DEF_IN_FM_SIZE  = 16384;
    localparam int DEF_WEIGHT_SIZE = 2304;
    localparam int DEF_OUT_FM_SIZE = 16384;
    localparam int DEF_IN_FM_BASE  = 0;
    localparam int DEF_WEIGHT_BASE = 16384;
    localparam int DEF_OUT_FM_BASE = 18688;

    // A zero-size stream still needs a 1-bit counter to keep the vectors legal.
    function automatic int cnt_w(input int size);
        return (size < 1) ? 1 : $clog2(size + 1);
    endfunction

endpackage

// File: rtl/rr_arb3.sv
// rtl/rr_arb3.sv - 3-way round-robin arbiter, combinational one-hot grant, registered pointer
module rr_arb3 (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic [2:0] i_req,
    output logic [2:0] o_gnt
);

    logic [1:0] r_ptr;
    logic [1:0] w_ptr_nxt;

    function automatic logic [2:0] pick(input logic [2:0] req, input logic [1:0] a,
                                        input logic [1:0] b, input logic [1:0] c);
        logic [2:0] g;
        g = 3'b000;
        if (req[a])      g[a] = 1'b1;
        else if (req[b]) g[b] = 1'b1;
        else if (req[c]) g[c] = 1'b1;
        return g;
    endfunction

    always_comb begin
        o_gnt = 3'b000;
        case (r_ptr)
            2'd1:    o_gnt = pick(i_req, 2'd1, 2'd2, 2'd0);
            2'd2:    o_gnt = pick(i_req, 2'd2, 2'd0, 2'd1);
            default: o_gnt = pick(i_req, 2'd0, 2'd1, 2'd2);
        endcase
    end

    always_comb begin
        w_ptr_nxt = r_ptr;
        if (o_gnt[0])      w_ptr_nxt = 2'd1;
        else if (o_gnt[1]) w_ptr_nxt = 2'd2;
        else if (o_gnt[2]) w_ptr_nxt = 2'd0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= 2'd0;
        end else if (i_clear) begin
            r_ptr <= 2'd0;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

endmodule

// File: rtl/conv_tile_load_sched.sv
// rtl/conv_tile_load_sched.sv - sequences one conv tile load from a shared read port into three FIFOs
module conv_tile_load_sched
    import conv_pkg::*;
#(
    parameter int AW          = 16,
    parameter int DW          = 32,
    parameter int RD_LAT      = 2,
    parameter int IN_FM_SIZE  = DEF_IN_FM_SIZE,
    parameter int WEIGHT_SIZE = DEF_WEIGHT_SIZE,
    parameter int OUT_FM_SIZE = DEF_OUT_FM_SIZE,
    parameter int IN_FM_BASE  = DEF_IN_FM_BASE,
    parameter int WEIGHT_BASE = DEF_WEIGHT_BASE,
    parameter int OUT_FM_BASE = DEF_OUT_FM_BASE
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tile_start,
    output logic          tile_busy,
    output logic          tile_load_done,
    output logic          mem_rd_ena,
    output logic [AW-1:0] mem_rd_addr,
    input  logic [DW-1:0] mem_rd_data,
    output logic          in_fm_push,
    output logic          weight_push,
    output logic          out_fm_push,
    output logic [DW-1:0] fifo_wr_data,
    input  logic          in_fm_almost_full,
    input  logic          weight_almost_full,
    input  logic          out_fm_almost_full
);

    localparam int IW = cnt_w(IN_FM_SIZE);
    localparam int WW = cnt_w(WEIGHT_SIZE);
    localparam int OW = cnt_w(OUT_FM_SIZE);
    localparam logic [IW-1:0] IN_SZ = IW'(IN_FM_SIZE);
    localparam logic [WW-1:0] W_SZ  = WW'(WEIGHT_SIZE);
    localparam logic [OW-1:0] O_SZ  = OW'(OUT_FM_SIZE);

    state_t r_state, w_state_nxt;
    logic [IW-1:0] r_in_iss, r_in_push, w_in_iss_nxt, w_in_push_nxt;
    logic [WW-1:0] r_w_iss,  r_w_push,  w_w_iss_nxt,  w_w_push_nxt;
    logic [OW-1:0] r_o_iss,  r_o_push,  w_o_iss_nxt,  w_o_push_nxt;
    logic [2:0]    w_req, w_gnt;
    stream_t       w_gnt_id;
    logic [RD_LAT-1:0]      r_tag_vld;
    logic [RD_LAT-1:0][1:0] r_tag_id;
    logic [1:0]    w_tag_id;
    logic          w_start, w_iss_all, w_push_all;

    assign w_start = (r_state == S_IDLE) && tile_start;

    assign w_req[0] = (r_state == S_LOAD) && (r_in_iss < IN_SZ) && !in_fm_almost_full;
    assign w_req[1] = (r_state == S_LOAD) && (r_w_iss  < W_SZ)  && !weight_almost_full;
    assign w_req[2] = (r_state == S_LOAD) && (r_o_iss  < O_SZ)  && !out_fm_almost_full;

    rr_arb3 u_arb (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_start),
        .i_req   (w_req),
        .o_gnt   (w_gnt)
    );

    always_comb begin
        mem_rd_addr = '0;
        w_gnt_id    = ST_IN_FM;
        if (w_gnt[0]) begin
            mem_rd_addr = AW'(IN_FM_BASE) + AW'(r_in_iss);
        end else if (w_gnt[1]) begin
            mem_rd_addr = AW'(WEIGHT_BASE) + AW'(r_w_iss);
            w_gnt_id    = ST_WEIGHT;
        end else if (w_gnt[2]) begin
            mem_rd_addr = AW'(OUT_FM_BASE) + AW'(r_o_iss);
            w_gnt_id    = ST_OUT_FM;
        end
    end

    assign mem_rd_ena = |w_gnt;

    // The tag pipe mirrors the port latency, so its head lines up with mem_rd_data.
    assign w_tag_id     = r_tag_id[RD_LAT-1];
    assign in_fm_push   = r_tag_vld[RD_LAT-1] && (w_tag_id == ST_IN_FM);
    assign weight_push  = r_tag_vld[RD_LAT-1] && (w_tag_id == ST_WEIGHT);
    assign out_fm_push  = r_tag_vld[RD_LAT-1] && (w_tag_id == ST_OUT_FM);
    assign fifo_wr_data = (in_fm_push || weight_push || out_fm_push) ? mem_rd_data : '0;

    assign w_in_iss_nxt  = r_in_iss  + IW'(w_gnt[0]);
    assign w_w_iss_nxt   = r_w_iss   + WW'(w_gnt[1]);
    assign w_o_iss_nxt   = r_o_iss   + OW'(w_gnt[2]);
    assign w_in_push_nxt = r_in_push + IW'(in_fm_push);
    assign w_w_push_nxt  = r_w_push  + WW'(weight_push);
    assign w_o_push_nxt  = r_o_push  + OW'(out_fm_push);

    // Completion includes this cycle's issue/push so no idle cycle is spent per phase.
    assign w_iss_all  = (w_in_iss_nxt == IN_SZ) && (w_w_iss_nxt == W_SZ) && (w_o_iss_nxt == O_SZ);
    assign w_push_all = (w_in_push_nxt == IN_SZ) && (w_w_push_nxt == W_SZ) && (w_o_push_nxt == O_SZ);

    always_comb begin
        w_state_nxt    = r_state;
        tile_busy      = 1'b0;
        tile_load_done = 1'b0;
        case (r_state)
            S_IDLE:  if (tile_start) w_state_nxt = S_LOAD;
            S_LOAD: begin
                tile_busy = 1'b1;
                if (w_iss_all) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                tile_busy = 1'b1;
                if (w_push_all) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                tile_load_done = 1'b1;
                w_state_nxt    = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_in_iss  <= '0;
            r_w_iss   <= '0;
            r_o_iss   <= '0;
            r_in_push <= '0;
            r_w_push  <= '0;
            r_o_push  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_in_iss  <= '0;
                r_w_iss   <= '0;
                r_o_iss   <= '0;
                r_in_push <= '0;
                r_w_push  <= '0;
                r_o_push  <= '0;
            end else begin
                r_in_iss  <= w_in_iss_nxt;
                r_w_iss   <= w_w_iss_nxt;
                r_o_iss   <= w_o_iss_nxt;
                r_in_push <= w_in_push_nxt;
                r_w_push  <= w_w_push_nxt;
                r_o_push  <= w_o_push_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tag_vld <= '0;
            r_tag_id  <= '0;
        end else begin
            r_tag_vld[0] <= mem_rd_ena;
            r_tag_id[0]  <= w_gnt_id;
            for (int k = 1; k < RD_LAT; k++) begin
                r_tag_vld[k] <= r_tag_vld[k-1];
                r_tag_id[k]  <= r_tag_id[k-1];
            end
        end
    end

endmodule

// File: tb/tb_conv_tile_load_sched.sv
// tb/tb_conv_tile_load_sched.sv - directed self-checking bench for conv_tile_load_sched
module tb_conv_tile_load_sched;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int RD_LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, tile_start, tile_start_z, w_af;
    logic tile_busy, tile_load_done, mem_rd_ena, in_fm_push, weight_push, out_fm_push;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data, fifo_wr_data;
    logic z_busy, z_done, z_ena, z_in_push, z_w_push, z_o_push;
    logic [AW-1:0] z_addr;
    logic [DW-1:0] z_rd_data, z_wr_data;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int t0 = 0;
    int t0z = 0;

    conv_tile_load_sched #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .IN_FM_SIZE(8), .WEIGHT_SIZE(4),
        .OUT_FM_SIZE(8), .IN_FM_BASE(0), .WEIGHT_BASE(100), .OUT_FM_BASE(200)) dut (
        .clk(clk), .rst(rst), .tile_start(tile_start), .tile_busy(tile_busy),
        .tile_load_done(tile_load_done), .mem_rd_ena(mem_rd_ena), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data), .in_fm_push(in_fm_push), .weight_push(weight_push),
        .out_fm_push(out_fm_push), .fifo_wr_data(fifo_wr_data), .in_fm_almost_full(1'b0),
        .weight_almost_full(w_af), .out_fm_almost_full(1'b0));

    conv_tile_load_sched #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .IN_FM_SIZE(8), .WEIGHT_SIZE(0),
        .OUT_FM_SIZE(8), .IN_FM_BASE(0), .WEIGHT_BASE(100), .OUT_FM_BASE(200)) dut_z (
        .clk(clk), .rst(rst), .tile_start(tile_start_z), .tile_busy(z_busy),
        .tile_load_done(z_done), .mem_rd_ena(z_ena), .mem_rd_addr(z_addr),
        .mem_rd_data(z_rd_data), .in_fm_push(z_in_push), .weight_push(z_w_push),
        .out_fm_push(z_o_push), .fifo_wr_data(z_wr_data), .in_fm_almost_full(1'b0),
        .weight_almost_full(1'b0), .out_fm_almost_full(1'b0));

    always @(posedge clk) cyc <= cyc + 1;

    // memory models: data = address, garbage when no read is returning
    logic [1:0] ma_vld, mz_vld;
    logic [1:0][AW-1:0] ma_addr, mz_addr;
    always @(posedge clk) begin
        ma_vld  <= {ma_vld[0], mem_rd_ena};
        ma_addr <= {ma_addr[0], mem_rd_addr};
        mz_vld  <= {mz_vld[0], z_ena};
        mz_addr <= {mz_addr[0], z_addr};
    end
    assign mem_rd_data = ma_vld[1] ? {16'h0, ma_addr[1]} : 32'hDEAD_BEEF;
    assign z_rd_data   = mz_vld[1] ? {16'h0, mz_addr[1]} : 32'hDEAD_BEEF;

    int iss_addr[$], iss_rel[$], push_sid[$], push_data[$], push_rel[$], done_q[$], busy_q[$];
    int multi_push = 0;
    int z_iss_addr[$], z_iss_rel[$], z_done_q[$];
    int z_push_cnt = 0;
    int z_wpush_cnt = 0;

    always @(negedge clk) begin : mon
        int r;
        r = cyc - t0;
        if (mem_rd_ena) begin
            iss_addr.push_back(int'(mem_rd_addr));
            iss_rel.push_back(r);
        end
        if (in_fm_push || weight_push || out_fm_push) begin
            if (int'(in_fm_push) + int'(weight_push) + int'(out_fm_push) > 1) multi_push++;
            push_sid.push_back(in_fm_push ? 0 : (weight_push ? 1 : 2));
            push_data.push_back(int'(fifo_wr_data));
            push_rel.push_back(r);
        end
        if (tile_load_done) done_q.push_back(r);
        if (tile_busy) busy_q.push_back(r);
        r = cyc - t0z;
        if (z_ena) begin
            z_iss_addr.push_back(int'(z_addr));
            z_iss_rel.push_back(r);
        end
        if (z_in_push || z_w_push || z_o_push) z_push_cnt++;
        if (z_w_push) z_wpush_cnt++;
        if (z_done) z_done_q.push_back(r);
    end

    task automatic run_tile(input int bp_lo, input int bp_hi, input int restart_rel);
        int d0, r;
        d0 = done_q.size();
        @(posedge clk); #1;
        t0 = cyc;
        tile_start = 1'b1;
        for (int k = 0; k < 200 && done_q.size() == d0; k++) begin
            @(posedge clk); #1;
            r = cyc - t0;
            tile_start = (r == restart_rel);
            w_af = (r >= bp_lo && r <= bp_hi);
        end
        tile_start = 1'b0;
        w_af = 1'b0;
        n_checks++;
        if (done_q.size() == d0) begin
            n_fail++;
            $display("FAIL run_tile_timeout: done pulses %0d, required at least 1", done_q.size() - d0);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; tile_start = 1'b0; tile_start_z = 1'b0; w_af = 1'b0;
        #2;
        n_checks++;
        if ({tile_busy, tile_load_done, mem_rd_ena, in_fm_push, weight_push, out_fm_push} !== 6'b0 ||
            mem_rd_addr !== 16'h0 || fifo_wr_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: ena=%0b addr=%0d data=%0h busy=%0b, required all 0",
                     mem_rd_ena, mem_rd_addr, fifo_wr_data, tile_busy);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({tile_busy, tile_load_done, mem_rd_ena, z_busy, z_ena} !== 5'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%0b done=%0b ena=%0b, required 0", tile_busy,
                     tile_load_done, mem_rd_ena);
        end
    endtask

    task automatic test_basic();
        int ib, db, bb, pb;
        int exp_a[20] = '{0, 100, 200, 1, 101, 201, 2, 102, 202, 3, 103, 203, 4, 204, 5, 205, 6, 206, 7, 207};
        ib = iss_addr.size(); db = done_q.size(); bb = busy_q.size(); pb = push_rel.size();
        run_tile(1, 0, -1);
        n_checks++;
        if (iss_addr.size() - ib != 20) begin
            n_fail++;
            $display("FAIL basic_issue_count: got %0d required 20", iss_addr.size() - ib);
        end
        for (int k = 0; k < 20 && ib + k < iss_addr.size(); k++) begin
            n_checks++;
            if (iss_addr[ib + k] != exp_a[k] || iss_rel[ib + k] != k + 1) begin
                n_fail++;
                $display("FAIL basic_issue[%0d]: addr %0d at cycle %0d, required %0d at cycle %0d",
                         k, iss_addr[ib + k], iss_rel[ib + k], exp_a[k], k + 1);
            end
        end
        n_checks++;
        if (push_rel.size() - pb != 20 || push_rel[push_rel.size() - 1] != 22) begin
            n_fail++;
            $display("FAIL basic_last_push: %0d pushes, last at cycle %0d, required 20 with last at 22",
                     push_rel.size() - pb, push_rel[push_rel.size() - 1]);
        end
        n_checks++;
        if (done_q.size() - db != 1 || done_q[done_q.size() - 1] != 23) begin
            n_fail++;
            $display("FAIL basic_done: %0d pulses, last at cycle %0d, required 1 at 23",
                     done_q.size() - db, done_q[done_q.size() - 1]);
        end
        n_checks++;
        if (busy_q.size() - bb != 22 || busy_q[bb] != 1 || busy_q[busy_q.size() - 1] != 22) begin
            n_fail++;
            $display("FAIL basic_busy: %0d cycles from %0d to %0d, required 22 cycles 1..22",
                     busy_q.size() - bb, busy_q[bb], busy_q[busy_q.size() - 1]);
        end
    endtask

    task automatic test_push_data();
        int ib, pb, m0, nxt_in, nxt_w, nxt_o, sid, exp_d;
        ib = iss_addr.size(); pb = push_rel.size(); m0 = multi_push;
        nxt_in = 0; nxt_w = 100; nxt_o = 200;
        run_tile(1, 0, -1);
        n_checks++;
        if (push_rel.size() - pb != 20 || multi_push != m0) begin
            n_fail++;
            $display("FAIL push_count: got %0d pushes (%0d multi-hot), required 20 and 0",
                     push_rel.size() - pb, multi_push - m0);
        end
        for (int k = 0; pb + k < push_rel.size() && ib + k < iss_addr.size(); k++) begin
            sid = push_sid[pb + k];
            exp_d = (sid == 0) ? nxt_in : ((sid == 1) ? nxt_w : nxt_o);
            n_checks++;
            if (push_data[pb + k] != exp_d || iss_addr[ib + k] != exp_d ||
                push_rel[pb + k] != iss_rel[ib + k] + RD_LAT) begin
                n_fail++;
                $display("FAIL push_data[%0d]: stream %0d data %0d at cycle %0d, required %0d at cycle %0d",
                         k, sid, push_data[pb + k], push_rel[pb + k], exp_d, iss_rel[ib + k] + RD_LAT);
            end
            if (sid == 0) nxt_in++;
            else if (sid == 1) nxt_w++;
            else nxt_o++;
        end
        n_checks++;
        if (nxt_in != 8 || nxt_w != 104 || nxt_o != 208) begin
            n_fail++;
            $display("FAIL push_stream_ends: next %0d/%0d/%0d, required 8/104/208", nxt_in, nxt_w, nxt_o);
        end
    endtask

    task automatic test_backpressure();
        int ib, pb, db, bad, cin, cw, co, wrel, wdat;
        int exp_a[20] = '{0, 100, 200, 1, 201, 2, 202, 3, 203, 4, 101, 204, 5, 102, 205, 6, 103, 206, 7, 207};
        ib = iss_addr.size(); pb = push_rel.size(); db = done_q.size();
        bad = 0; cin = 0; cw = 0; co = 0; wrel = -1; wdat = -1;
        run_tile(3, 10, -1);
        for (int k = 0; k < 20 && ib + k < iss_addr.size(); k++) begin
            n_checks++;
            if (iss_addr[ib + k] != exp_a[k]) begin
                n_fail++;
                $display("FAIL bp_issue[%0d]: addr %0d, required %0d", k, iss_addr[ib + k], exp_a[k]);
            end
        end
        for (int k = ib; k < iss_addr.size(); k++) begin
            if (iss_addr[k] >= 100 && iss_addr[k] < 200 && iss_rel[k] >= 3 && iss_rel[k] <= 10) bad++;
            if (iss_addr[k] < 100) cin++;
            else if (iss_addr[k] < 200) cw++;
            else co++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bp_weight_blocked: %0d weight issues in cycles 3..10, required 0", bad);
        end
        n_checks++;
        if (cin != 8 || cw != 4 || co != 8) begin
            n_fail++;
            $display("FAIL bp_issue_counts: %0d/%0d/%0d, required 8/4/8", cin, cw, co);
        end
        cin = 0; cw = 0; co = 0;
        for (int k = pb; k < push_rel.size(); k++) begin
            if (push_sid[k] == 0) cin++;
            else if (push_sid[k] == 1) begin
                cw++;
                if (wrel < 0) begin wrel = push_rel[k]; wdat = push_data[k]; end
            end else co++;
        end
        n_checks++;
        if (cin != 8 || cw != 4 || co != 8) begin
            n_fail++;
            $display("FAIL bp_push_counts: %0d/%0d/%0d, required 8/4/8", cin, cw, co);
        end
        n_checks++;
        if (wrel != 4 || wdat != 100) begin
            n_fail++;
            $display("FAIL bp_inflight_weight: first weight push data %0d at cycle %0d, required 100 at 4",
                     wdat, wrel);
        end
        n_checks++;
        if (done_q.size() - db != 1 || done_q[done_q.size() - 1] != 23) begin
            n_fail++;
            $display("FAIL bp_done: %0d pulses, last at %0d, required 1 at 23", done_q.size() - db,
                     done_q[done_q.size() - 1]);
        end
    endtask

    task automatic test_restart_ignored();
        int ib, pb, db, cin, cw, co;
        ib = iss_addr.size(); pb = push_rel.size(); db = done_q.size();
        cin = 0; cw = 0; co = 0;
        run_tile(1, 0, 5);
        for (int k = pb; k < push_rel.size(); k++) begin
            if (push_sid[k] == 0) cin++;
            else if (push_sid[k] == 1) cw++;
            else co++;
        end
        n_checks++;
        if (iss_addr.size() - ib != 20 || cin != 8 || cw != 4 || co != 8) begin
            n_fail++;
            $display("FAIL restart_counts: %0d issues, pushes %0d/%0d/%0d, required 20 and 8/4/8",
                     iss_addr.size() - ib, cin, cw, co);
        end
        n_checks++;
        if (done_q.size() - db != 1 || done_q[done_q.size() - 1] != 23) begin
            n_fail++;
            $display("FAIL restart_done: %0d pulses, last at %0d, required 1 at 23", done_q.size() - db,
                     done_q[done_q.size() - 1]);
        end
    endtask

    task automatic test_reset_midop();
        int ib, pb, db;
        @(posedge clk); #1;
        t0 = cyc;
        tile_start = 1'b1;
        @(posedge clk); #1;
        tile_start = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if ({tile_busy, tile_load_done, mem_rd_ena, in_fm_push, weight_push, out_fm_push} !== 6'b0 ||
            mem_rd_addr !== 16'h0 || fifo_wr_data !== 32'h0) begin
            n_fail++;
            $display("FAIL midop_reset_outputs: ena=%0b addr=%0d data=%0h busy=%0b, required all 0",
                     mem_rd_ena, mem_rd_addr, fifo_wr_data, tile_busy);
        end
        ib = iss_addr.size(); pb = push_rel.size();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (push_rel.size() != pb || iss_addr.size() != ib) begin
            n_fail++;
            $display("FAIL midop_no_push: %0d pushes and %0d issues after reset, required 0 and 0",
                     push_rel.size() - pb, iss_addr.size() - ib);
        end
        db = done_q.size();
        run_tile(1, 0, -1);
        n_checks++;
        if (iss_addr.size() - ib != 20 || iss_addr[ib] != 0 || iss_addr[ib + 1] != 100 ||
            iss_addr[ib + 2] != 200) begin
            n_fail++;
            $display("FAIL midop_reload: %0d issues starting %0d,%0d,%0d, required 20 starting 0,100,200",
                     iss_addr.size() - ib, iss_addr[ib], iss_addr[ib + 1], iss_addr[ib + 2]);
        end
        n_checks++;
        if (done_q.size() - db != 1 || push_rel.size() - pb != 20) begin
            n_fail++;
            $display("FAIL midop_complete: %0d done pulses, %0d pushes, required 1 and 20",
                     done_q.size() - db, push_rel.size() - pb);
        end
    endtask

    task automatic test_zero_weight();
        int ib, db, p0, w0, exp_d;
        ib = z_iss_addr.size(); db = z_done_q.size(); p0 = z_push_cnt; w0 = z_wpush_cnt;
        @(posedge clk); #1;
        t0z = cyc;
        tile_start_z = 1'b1;
        @(posedge clk); #1;
        tile_start_z = 1'b0;
        for (int k = 0; k < 200 && z_done_q.size() == db; k++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (z_done_q.size() - db != 1 || z_done_q[z_done_q.size() - 1] != 19) begin
            n_fail++;
            $display("FAIL zero_done: %0d pulses, last at %0d, required 1 at 19", z_done_q.size() - db,
                     z_done_q[z_done_q.size() - 1]);
        end
        n_checks++;
        if (z_iss_addr.size() - ib != 16 || z_push_cnt - p0 != 16 || z_wpush_cnt != w0) begin
            n_fail++;
            $display("FAIL zero_counts: %0d issues, %0d pushes, %0d weight pushes, required 16/16/0",
                     z_iss_addr.size() - ib, z_push_cnt - p0, z_wpush_cnt - w0);
        end
        for (int k = 0; k < 16 && ib + k < z_iss_addr.size(); k++) begin
            exp_d = (k % 2 == 0) ? k / 2 : 200 + k / 2;
            n_checks++;
            if (z_iss_addr[ib + k] != exp_d || z_iss_rel[ib + k] != k + 1) begin
                n_fail++;
                $display("FAIL zero_issue[%0d]: addr %0d at %0d, required %0d at %0d", k,
                         z_iss_addr[ib + k], z_iss_rel[ib + k], exp_d, k + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_push_data();
        test_backpressure();
        test_restart_ignored();
        test_reset_midop();
        test_zero_weight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
